imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time loader and run-gate for the single-cycle core's instruction memory. Accepts a stream of 32-bit instruction words over a valid/ready handshake and drives the instruction memory write port at sequential word addresses starting at 0. Holds the core in a non-running state until the program is completely written, then asserts `core_run` so fetch can begin from address 0.

## Interface
Parameters:
- `DEPTH`, 32: instruction memory depth in 32-bit words.
- `ADDR_W`, `$clog2(DEPTH)`: width of a word address.

Ports:
- `clk`, in, 1: the only clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle request to begin a load.
- `word_valid`, in, 1: an instruction word is offered.
- `word_data`, in, 32: the offered instruction word.
- `word_last`, in, 1: qualifies the final program word. Sampled only on an accepted beat.
- `word_ready`, out, 1: the loader accepts a beat this cycle.
- `mem_we`, out, 1: instruction memory write strobe.
- `mem_waddr`, out, ADDR_W: word address for the write. The byte address equals `mem_waddr << 2`.
- `mem_wdata`, out, 32: the word to write.
- `core_run`, out, 1: high when the core may fetch.
- `load_count`, out, ADDR_W+1: number of words written in the current or last load.
- `busy`, out, 1: high in LOAD, CHECK and DONE.
- `overflow_err`, out, 1: the program exceeded `DEPTH` words.
- `checksum_err`, out, 1: the checksum did not match. Tied to 0 without the macro.

## Operation
States: IDLE, LOAD, CHECK, DONE, RUN, ERROR.

Reset values:
- State is IDLE.
- All outputs are 0, including `load_count`.

Transitions:
- **IDLE:** `word_ready`=0. On `start`, go to LOAD and clear `load_count` and the address.
- **LOAD:** `word_ready`=1. A beat is accepted when `word_valid && word_ready`. Each accepted beat:
  - writes to the current address;
  - increments the address and `load_count`.
  - Accepted beat with `word_last`=1: go to CHECK if the macro is defined, else DONE.
  - Accepted beat at address `DEPTH-1` with `word_last`=0: go to ERROR and set `overflow_err`.
  - `start` is ignored in this state.
- **CHECK (macro only):** `word_ready`=1. The next accepted beat is the expected checksum and is not written to memory.
  - Match: go to DONE.
  - Mismatch: go to ERROR and set `checksum_err`.
- **DONE:** lasts exactly one cycle, then RUN.
- **RUN:** `core_run`=1. On `start`, go to LOAD. `core_run` falls on the next cycle, and `load_count` and the address clear.
- **ERROR:** `core_run`=0 and `word_ready`=0. The error flags stay set. On `start`, go to LOAD and clear the flags.

Other rules:
- Address arithmetic is ADDR_W bits wide and never wraps, because the overflow check fires first.
- `load_count` saturates at DEPTH.
- A single-word program (`word_last` on the first beat) is legal.
- Reset mid-load returns to IDLE on the next edge. Memory contents are left as written.

## Timing
- Write latency is 1 cycle. A beat accepted in cycle N gives `mem_we`=1 in N+1, with the address and data of that beat. Otherwise `mem_we` is 0.
- The last beat accepted in cycle N (no macro) gives:
  - N+1: last `mem_we`, state DONE.
  - N+2: `core_run`=1.
- With the macro, `core_run` rises 2 cycles after the checksum beat is accepted.
- `word_ready` is a registered function of state. When a transition leaves LOAD, ready is already 0 in the following cycle.
- `overflow_err` and `checksum_err` are set in the cycle after the offending beat.
- Beats offered while ready is 0 are not consumed. The sender holds them.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - a 32-bit running sum (modulo 2^32) of the written words is kept;
  - the CHECK state exists;
  - one extra beat after `word_last` carries the expected sum.
- Not defined:
  - no accumulator and no CHECK state;
  - `word_last` leads straight to DONE;
  - `checksum_err`=0.

## Structure
- Package `imem_loader_pkg` holds:
  - the state enum `loader_state_t`;
  - `INSTR_W`=32;
  - `IMEM_DEPTH_DEFAULT`=32.
- Optional sub-module `imem_checksum` (accumulator with clear, add and compare) is instantiated only under the macro.

## Test plan
- **Basic load.** Reset, pulse `start`, send 0x00000013, 0x00100093, 0x00208133 with `word_last` on the third. Expect:
  - `mem_we` at addresses 0/1/2 with that data;
  - `core_run`=1 two cycles after the third accept;
  - `load_count`=3.
- **Valid gaps.** Toggle `word_valid` 1-0-1-1-0-1 over 4 words. Expect writes only on handshakes, with contiguous addresses 0..3.
- **Overflow.** DEPTH=32, 32 beats with no `word_last`. Expect:
  - `overflow_err`=1 the cycle after the 32nd accept;
  - `word_ready`=0 and `core_run`=0;
  - a later `start` clears the flag.
- **Reset mid-load.** Assert `reset` after 5 words. Expect:
  - all outputs 0 on the next cycle;
  - a new `start` reloads from address 0.
- **Reload from RUN.** Pulse `start` while in RUN. Expect `core_run`=0 on the next cycle, and the first new write at address 0.
- **Checksum (macro defined).**
  - Words 1, 2, 3 followed by 6: RUN is reached.
  - Words 1, 2, 3 followed by 7: `checksum_err`=1 and `core_run` stays 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional checksum feature: IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int INSTR_W = 32;
  localparam int IMEM_DEPTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_RUN,
    S_ERROR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_checksum.sv
// Running modulo-2^32 sum of loaded words with clear, add and compare.
// Only instantiated when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_checksum
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               add,
  input  logic [INSTR_W-1:0] add_data,
  input  logic [INSTR_W-1:0] cmp_data,
  output logic               match
);

  logic [INSTR_W-1:0] sum_q;
  logic [INSTR_W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add) begin
      sum_d = sum_q + add_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign match = (sum_q == cmp_data);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams words into imem, then releases the core.
// Define IMEM_LOADER_CHECKSUM_EN for a trailing checksum beat.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               word_valid,
  input  logic [INSTR_W-1:0] word_data,
  input  logic               word_last,
  output logic               word_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               core_run,
  output logic [ADDR_W:0]    load_count,
  output logic               busy,
  output logic               overflow_err,
  output logic               checksum_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   MAX_CNT   = (ADDR_W+1)'(DEPTH);

  loader_state_t      state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               ready_q, ready_d;
  logic               run_q, run_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic               cks_q, cks_d;
  logic               accept;
  logic               cks_clr;
  logic               cks_add;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic cks_match;

  imem_checksum u_checksum (
    .clk      (clk),
    .reset    (reset),
    .clr      (cks_clr),
    .add      (cks_add),
    .add_data (word_data),
    .cmp_data (word_data),
    .match    (cks_match)
  );
`else
  logic unused_cks;
  assign unused_cks = cks_clr | cks_add;
`endif

  assign accept = word_valid && ready_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
    cks_d   = cks_q;
    cks_clr = 1'b0;
    cks_add = 1'b0;

    unique case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          cks_d   = 1'b0;
          cks_clr = 1'b1;
        end
      end
      S_LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = word_data;
          cks_add = 1'b1;
          // Hold the address at the top so it never wraps.
          if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
          if (cnt_q != MAX_CNT) cnt_d = cnt_q + 1'b1;
          if (word_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else if (addr_q == LAST_ADDR) begin
            state_d = S_ERROR;
            ovf_d   = 1'b1;
          end
        end
      end
      S_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) begin
          if (cks_match) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
            cks_d   = 1'b1;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
    run_d   = (state_d == S_RUN);
    busy_d  = (state_d == S_LOAD) || (state_d == S_CHECK) ||
              (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cks_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      cks_q   <= cks_d;
    end
  end

  assign word_ready   = ready_q;
  assign mem_we       = we_q;
  assign mem_waddr    = waddr_q;
  assign mem_wdata    = wdata_q;
  assign core_run     = run_q;
  assign load_count   = cnt_q;
  assign busy         = busy_q;
  assign overflow_err = ovf_q;
  assign checksum_err = cks_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued by the
// driver, popped by a write monitor; control outputs checked inline.
module tb_imem_loader;

  localparam int DEPTH = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          word_valid;
  logic [31:0]   word_data;
  logic          word_last;
  logic          word_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          core_run;
  logic [AW:0]   load_count;
  logic          busy;
  logic          overflow_err;
  logic          checksum_err;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_last    (word_last),
    .word_ready   (word_ready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .core_run     (core_run),
    .load_count   (load_count),
    .busy         (busy),
    .overflow_err (overflow_err),
    .checksum_err (checksum_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] prog[$];
  int          gaps[$];
  int          idx;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".ready"}, word_ready, 0);
    chk({name, ".we"}, mem_we, 0);
    chk({name, ".waddr"}, mem_waddr, 0);
    chk({name, ".wdata"}, mem_wdata, 0);
    chk({name, ".run"}, core_run, 0);
    chk({name, ".count"}, load_count, 0);
    chk({name, ".busy"}, busy, 0);
    chk({name, ".ovf"}, overflow_err, 0);
    chk({name, ".cks"}, checksum_err, 0);
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h expected none",
                 mem_waddr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("waddr", 64'(mem_waddr), 64'(e.addr));
        chk("wdata", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
  endtask

  // Offer one beat; returns just after the accepting edge.
  task automatic send(input logic [31:0] d, input logic l,
                      input int gap, input bit is_write);
    bit acc;
    int n;
    word_valid = 1'b0;
    repeat (gap) tick();
    word_valid = 1'b1;
    word_data = d;
    word_last = l;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = (word_ready === 1'b1);
      tick();
      n++;
    end
    word_valid = 1'b0;
    word_last = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no ready expected ready");
    end else if (is_write) begin
      exp_q.push_back('{addr: idx, data: d});
      idx++;
    end
  endtask

  // Load prog[] with gaps[]; bad adds an error to the checksum beat.
  task automatic load_prog(input bit bad);
    logic [31:0] sum;
    int n;
    n = prog.size();
    sum = 0;
    for (int i = 0; i < n; i++) begin
      send(prog[i], i == n - 1, gaps[i], 1'b1);
      sum = sum + prog[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("check.ready", word_ready, 1);
    send(sum + 32'(bad), 1'b0, 0, 1'b0);
    chk("cks_err_now", checksum_err, 64'(bad));
`endif
    chk("run_early", core_run, 0);
    chk("ready_after", word_ready, 0);
    tick();
    if (bad) begin
      chk("cks_err", checksum_err, 1);
      chk("run_bad", core_run, 0);
      tick();
      chk("run_bad2", core_run, 0);
    end else begin
      chk("run", core_run, 1);
      chk("count", load_count, 64'(n > DEPTH ? DEPTH : n));
      chk("busy_run", busy, 0);
    end
  endtask

  task automatic rand_prog(input int n, input int gmax);
    prog.delete();
    gaps.delete();
    for (int i = 0; i < n; i++) begin
      prog.push_back($urandom);
      gaps.push_back($urandom_range(0, gmax));
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    word_valid = 1'b0;
    word_data = '0;
    word_last = 1'b0;
    idx = 0;
    repeat (2) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();
    chk("idle_ready", word_ready, 0);

    // basic load
    do_start();
    chk("load_ready", word_ready, 1);
    chk("load_busy", busy, 1);
    prog = '{32'h00000013, 32'h00100093, 32'h00208133};
    gaps = '{0, 0, 0};
    load_prog(1'b0);

    // valid gaps 1-0-1-1-0-1
    do_start();
    rand_prog(4, 0);
    gaps = '{0, 1, 0, 1};
    load_prog(1'b0);

    // single-word program
    do_start();
    rand_prog(1, 2);
    load_prog(1'b0);

    // random programs
    for (int r = 0; r < 5; r++) begin
      do_start();
      rand_prog($urandom_range(1, 12), 2);
      load_prog(1'b0);
    end

    // full depth with last on the final slot
    do_start();
    rand_prog(DEPTH, 1);
    load_prog(1'b0);
    chk("full_ovf", overflow_err, 0);

    // reload from RUN
    do_start();
    chk("reload_run", core_run, 0);
    chk("reload_count", load_count, 0);
    chk("reload_busy", busy, 1);
    rand_prog(2, 1);
    load_prog(1'b0);

    // overflow
    do_start();
    for (int i = 0; i < DEPTH; i++) send($urandom, 1'b0, $urandom_range(0, 1), 1'b1);
    chk("ovf", overflow_err, 1);
    chk("ovf_ready", word_ready, 0);
    chk("ovf_run", core_run, 0);
    chk("ovf_count", load_count, DEPTH);
    word_valid = 1'b1;
    word_data = 32'hdead_beef;
    repeat (3) tick();
    chk("ovf_hold", word_ready, 0);
    chk("ovf_sticky", overflow_err, 1);
    word_valid = 1'b0;
    do_start();
    chk("ovf_clear", overflow_err, 0);
    rand_prog(3, 1);
    load_prog(1'b0);

    // reset mid-load
    do_start();
    for (int i = 0; i < 5; i++) send($urandom, 1'b0, 0, 1'b1);
    reset = 1'b1;
    tick();
    chk_zero("midreset");
    reset = 1'b0;
    do_start();
    rand_prog(3, 1);
    load_prog(1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_start();
    prog = '{32'd1, 32'd2, 32'd3};
    gaps = '{0, 0, 0};
    load_prog(1'b0);
    do_start();
    prog = '{32'd1, 32'd2, 32'd3};
    load_prog(1'b1);
    do_start();
    chk("cks_clear", checksum_err, 0);
    rand_prog(2, 0);
    load_prog(1'b0);
`endif

    repeat (2) tick();
    chk("pending_writes", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
